// File: rtl/vpu_pkg.sv
// vpu_pkg: shared vector-unit widths and register-address/data types
package vpu_pkg;
  localparam int VPU_VLEN = 256;
  localparam int VREG_ADDR_W = 5;
  localparam int NUM_VREGS = 32;
  typedef logic [VREG_ADDR_W-1:0] vreg_addr_t;
  typedef logic [VPU_VLEN-1:0] vreg_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o,
  output logic               vld_o
);
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
        idx_o = PW'((int'(ptr_i) + k) % NUM_REQ);
        vld_o = 1'b1;
      end
    end
  end
  assign gnt_o = vld_o ? NUM_REQ'(1) << idx_o : '0;
endmodule

// File: rtl/vrf_wb_arbiter.sv
// vrf_wb_arbiter: round-robin VRF write-back arbiter with registered write port
// and a busy-bit scoreboard for RAW/WAW hazard detection at issue.
module vrf_wb_arbiter import vpu_pkg::*; #(
  parameter int VLEN = VPU_VLEN,
  parameter int NUM_REQ = 3,
  parameter int NUM_REGS = NUM_VREGS
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*VREG_ADDR_W-1:0] req_waddr_i,
  input  logic [NUM_REQ*VLEN-1:0]        req_wdata_i,
  output logic                           vrf_we_o,
  output vreg_addr_t                     vrf_waddr_o,
  output logic [VLEN-1:0]                vrf_wdata_o,
  input  logic                           rsv_valid_i,
  input  vreg_addr_t                     rsv_vd_i,
  input  vreg_addr_t                     chk_vs1_i,
  input  vreg_addr_t                     chk_vs2_i,
  input  vreg_addr_t                     chk_vs3_i,
  input  vreg_addr_t                     chk_vd_i,
  output logic                           hazard_o,
  output logic [NUM_REGS-1:0]            busy_o,
  input  logic                           flush_i
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] ptr_q, ptr_d, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic gnt_vld, we_q, we_d;
  vreg_addr_t waddr_q, waddr_d, gnt_addr;
  logic [VLEN-1:0] wdata_q, wdata_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req_i(req_valid_i),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx),
    .vld_o(gnt_vld)
  );

  assign gnt_addr = req_waddr_i[int'(gnt_idx)*VREG_ADDR_W +: VREG_ADDR_W];

  always_comb begin
    ptr_d = gnt_vld ? ((int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
    we_d = gnt_vld && (gnt_addr != '0);
    waddr_d = gnt_vld ? gnt_addr : waddr_q;
    wdata_d = gnt_vld ? req_wdata_i[int'(gnt_idx)*VLEN +: VLEN] : wdata_q;
    busy_d = busy_q;
    if (we_q) busy_d[waddr_q] = 1'b0;
    // Set after clear so a same-register reserve survives the commit.
    if (rsv_valid_i) busy_d[rsv_vd_i] = 1'b1;
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q <= busy_d;
    end
  end

  assign req_ready_o = rst_ni ? gnt : '0;
  assign vrf_we_o = we_q;
  assign vrf_waddr_o = waddr_q;
  assign vrf_wdata_o = wdata_q;
  assign busy_o = busy_q;
  assign hazard_o = rst_ni & (busy_q[chk_vs1_i] | busy_q[chk_vs2_i] | busy_q[chk_vs3_i] | busy_q[chk_vd_i]);
endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// tb_vrf_wb_arbiter: directed plus random stimulus checked against a behavioural model
module tb_vrf_wb_arbiter;
  localparam int VLEN = 256;
  localparam int N = 3;
  localparam int NR = 32;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  logic [N-1:0] req_valid_i = '0;
  logic [N-1:0] req_ready_o;
  logic [N*5-1:0] req_waddr_i = '0;
  logic [N*VLEN-1:0] req_wdata_i = '0;
  logic vrf_we_o;
  logic [4:0] vrf_waddr_o;
  logic [VLEN-1:0] vrf_wdata_o;
  logic rsv_valid_i = 1'b0;
  logic [4:0] rsv_vd_i = '0, chk_vs1_i = '0, chk_vs2_i = '0, chk_vs3_i = '0, chk_vd_i = '0;
  logic hazard_o;
  logic [NR-1:0] busy_o;
  logic flush_i = 1'b0;

  always #5 clk_i = ~clk_i;

  vrf_wb_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_waddr_i(req_waddr_i), .req_wdata_i(req_wdata_i),
    .vrf_we_o(vrf_we_o), .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o),
    .rsv_valid_i(rsv_valid_i), .rsv_vd_i(rsv_vd_i),
    .chk_vs1_i(chk_vs1_i), .chk_vs2_i(chk_vs2_i), .chk_vs3_i(chk_vs3_i), .chk_vd_i(chk_vd_i),
    .hazard_o(hazard_o), .busy_o(busy_o), .flush_i(flush_i)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit rv[N];
  logic [4:0] ra[N];
  logic [VLEN-1:0] rd[N];
  bit m_busy[NR];
  int m_ptr;
  bit m_we;
  logic [4:0] m_waddr;
  logic [VLEN-1:0] m_wdata;

  task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = rv[i];
      req_waddr_i[5*i +: 5] = ra[i];
      req_wdata_i[VLEN*i +: VLEN] = rd[i];
    end
  endtask

  function automatic logic [NR-1:0] pack_busy();
    logic [NR-1:0] b;
    for (int r = 0; r < NR; r++) b[r] = m_busy[r];
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
    m_ptr = 0;
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // One clock: called at a negedge with inputs prepared, returns at the next negedge.
  task automatic step();
    int g;
    logic [N-1:0] er;
    logic eh;
    drive();
    #1;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    eh = m_busy[chk_vs1_i] || m_busy[chk_vs2_i] || m_busy[chk_vs3_i] || m_busy[chk_vd_i];
    chk("ready", req_ready_o, er);
    chk("hazard", hazard_o, eh);
    chk("we", vrf_we_o, m_we);
    chk("waddr", vrf_waddr_o, m_waddr);
    chk("wdata", vrf_wdata_o, m_wdata);
    chk("busy", busy_o, pack_busy());
    if (flush_i) begin
      for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
    end else begin
      if (m_we) m_busy[m_waddr] = 1'b0;
      if (rsv_valid_i && rsv_vd_i != 0) m_busy[rsv_vd_i] = 1'b1;
    end
    if (g >= 0) begin
      m_we = (ra[g] != 0);
      m_waddr = ra[g];
      m_wdata = rd[g];
      m_ptr = (g + 1) % N;
      rv[g] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    drive();
    rst_ni = 1'b0;
    #1;
    chk("rst_we", vrf_we_o, 1'b0);
    chk("rst_waddr", vrf_waddr_o, 5'd0);
    chk("rst_wdata", vrf_wdata_o, '0);
    chk("rst_busy", busy_o, '0);
    chk("rst_ready", req_ready_o, '0);
    chk("rst_hazard", hazard_o, 1'b0);
    model_reset();
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    rsv_valid_i = 1'b0;
    flush_i = 1'b0;
    {chk_vs1_i, chk_vs2_i, chk_vs3_i, chk_vd_i} = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0;
      ra[i] = '0;
      rd[i] = '0;
    end
    model_reset();
    @(negedge clk_i);
    do_reset();

    // Single requester with prior reservation
    rsv_valid_i = 1'b1; rsv_vd_i = 5'd5;
    step();
    rsv_valid_i = 1'b0;
    rv[0] = 1'b1; ra[0] = 5'd5; rd[0] = VLEN'(32'hDEADBEEF);
    step();
    chk("t1_we", vrf_we_o, 1'b1);
    chk("t1_waddr", vrf_waddr_o, 5'd5);
    chk("t1_wdata", vrf_wdata_o[31:0], 32'hDEADBEEF);
    chk("t1_busy_before", busy_o[5], 1'b1);
    step();
    chk("t1_busy_after", busy_o[5], 1'b0);

    // Round-robin across three always-valid requesters
    do_reset();
    for (int i = 0; i < N; i++) begin
      ra[i] = 5'(i + 1);
      rd[i] = VLEN'(32'h1000 + i);
    end
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) rv[i] = 1'b1;
      drive();
      #1;
      chk("t2_order", req_ready_o, N'(1) << (c % N));
      step();
      if (c > 0) chk("t2_we_pulse", vrf_we_o, 1'b1);
    end

    // Hazard tracking through write commit
    rsv_valid_i = 1'b1; rsv_vd_i = 5'd7; chk_vs2_i = 5'd7;
    step();
    rsv_valid_i = 1'b0;
    rv[1] = 1'b1; ra[1] = 5'd7; rd[1] = VLEN'(32'h77);
    drive();
    #1;
    chk("t3_hazard_busy", hazard_o, 1'b1);
    step();
    chk("t3_hazard_on_port", hazard_o, 1'b1);
    step();
    chk("t3_hazard_cleared", hazard_o, 1'b0);
    chk_vs2_i = 5'd0;
    step();
    chk("t3_hazard_zero", hazard_o, 1'b0);

    // Set/clear collision on the same register
    rsv_valid_i = 1'b1; rsv_vd_i = 5'd9;
    step();
    rsv_valid_i = 1'b0;
    rv[2] = 1'b1; ra[2] = 5'd9; rd[2] = VLEN'(32'h99);
    step();
    rsv_valid_i = 1'b1; rsv_vd_i = 5'd9;
    step();
    rsv_valid_i = 1'b0;
    chk("t4_set_wins", busy_o[9], 1'b1);

    // v0 write-back, v0 reserve, and flush
    rv[0] = 1'b1; ra[0] = 5'd0; rd[0] = VLEN'(32'h55);
    drive();
    #1;
    chk("t5_ready_v0", req_ready_o[0], 1'b1);
    step();
    chk("t5_we_v0", vrf_we_o, 1'b0);
    rsv_valid_i = 1'b1; rsv_vd_i = 5'd0;
    step();
    chk("t5_busy0", busy_o[0], 1'b0);
    rsv_vd_i = 5'd3;
    step();
    rsv_vd_i = 5'd4;
    step();
    rsv_valid_i = 1'b0;
    chk("t5_busy34", busy_o[4:3], 2'b11);
    flush_i = 1'b1; rsv_valid_i = 1'b1; rsv_vd_i = 5'd6;
    step();
    flush_i = 1'b0; rsv_valid_i = 1'b0;
    chk("t5_flush", busy_o, '0);

    // Async reset with a write on the port and pointer at 2
    do_reset();
    rv[0] = 1'b1; ra[0] = 5'd1; rd[0] = VLEN'(32'hA0);
    rv[1] = 1'b1; ra[1] = 5'd2; rd[1] = VLEN'(32'hA1);
    rsv_valid_i = 1'b1; rsv_vd_i = 5'd10;
    step();
    rsv_valid_i = 1'b0;
    step();
    chk("t6_we_before", vrf_we_o, 1'b1);
    for (int i = 0; i < N; i++) rv[i] = 1'b1;
    do_reset();
    for (int i = 0; i < N; i++) rv[i] = 1'b1;
    drive();
    #1;
    chk("t6_first_grant", req_ready_o, 3'b001);
    step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(1, 0) == 1) begin
          rv[i] = 1'b1;
          ra[i] = 5'($urandom_range(31, 0));
          for (int w = 0; w < VLEN / 32; w++) rd[i][32*w +: 32] = $urandom();
        end
      end
      rsv_valid_i = ($urandom_range(2, 0) == 0);
      rsv_vd_i = 5'($urandom_range(31, 0));
      chk_vs1_i = 5'($urandom_range(15, 0));
      chk_vs2_i = 5'($urandom_range(15, 0));
      chk_vs3_i = 5'($urandom_range(15, 0));
      chk_vd_i = 5'($urandom_range(31, 0));
      flush_i = ($urandom_range(40, 0) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
